// File: rtl/stdp_upd_if.sv
// Weight-update request channel: valid/ready handshake carrying synapse index,
// spike-time difference and potentiation/depression flag.
interface stdp_upd_if #(
    parameter int TW = 4,
    parameter int IW = 2
);
    logic          upd_valid;
    logic          upd_ready;
    logic [IW-1:0] upd_idx;
    logic [TW-1:0] upd_dt;
    logic          upd_ltp;

    modport master (output upd_valid, output upd_idx, output upd_dt, output upd_ltp,
                    input  upd_ready);
    modport slave  (input  upd_valid, input  upd_idx, input  upd_dt, input  upd_ltp,
                    output upd_ready);
endinterface

// File: rtl/stdp_update_sched.sv
// STDP event scheduler: per-synapse spike timers, one pending update per synapse,
// round-robin serialisation onto one update port. Define STDP_LTD_EN to enable LTD events.
module stdp_update_sched #(
    parameter int NUM_PRE = 4,
    parameter int TW      = 4,
    parameter int IW      = 2
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [NUM_PRE-1:0] pre_spike,
    input  logic               post_spike,
    stdp_upd_if.master         upd,
    output logic               busy,
    output logic [7:0]         drop_cnt
);
    localparam logic [TW-1:0] TMAX = '1;

    typedef enum logic {S_IDLE, S_OFFER} state_t;

    state_t               state_reg;
    logic                 valid_reg;
    logic [IW-1:0]        idx_reg;
    logic [TW-1:0]        dt_reg;
    logic                 ltp_reg;
    logic [IW-1:0]        rr_reg;
    logic [NUM_PRE-1:0]   pend_reg;
    logic [TW-1:0]        pdt_reg [NUM_PRE];
    logic                 pltp_reg [NUM_PRE];
    logic [TW-1:0]        pt_reg [NUM_PRE];
    logic [TW-1:0]        qt_reg;
    logic [7:0]           drop_reg;

    logic [NUM_PRE-1:0]   tie, ltp_ev, ltd_ev, ev, ev_ltp;
    logic [TW-1:0]        ev_dt [NUM_PRE];
    logic                 found;
    logic [IW-1:0]        gidx;
    logic [NUM_PRE-1:0]   grant_vec;
    logic [4:0]           ovf_cnt;
    logic [8:0]           drop_sum;
    logic [7:0]           drop_next;

    function automatic logic [TW-1:0] sat_inc(input logic [TW-1:0] v);
        return (v == TMAX) ? v : v + TW'(1);
    endfunction

    // Event detection works on the timer values held at the start of the cycle.
    for (genvar gi = 0; gi < NUM_PRE; gi++) begin : g_event
        assign tie[gi]    = pre_spike[gi] & post_spike;
        assign ltp_ev[gi] = post_spike & (pt_reg[gi] != TMAX);
`ifdef STDP_LTD_EN
        assign ltd_ev[gi] = pre_spike[gi] & (qt_reg != TMAX);
`else
        assign ltd_ev[gi] = 1'b0;
`endif
        assign ev[gi]     = tie[gi] | ltp_ev[gi] | ltd_ev[gi];
        assign ev_ltp[gi] = tie[gi] | ltp_ev[gi];
        assign ev_dt[gi]  = tie[gi] ? '0 : (ltp_ev[gi] ? pt_reg[gi] : qt_reg);
    end

    // Round-robin search starts one past the last granted channel.
    always_comb begin
        int c;
        found = 1'b0;
        gidx  = '0;
        c     = 0;
        for (int k = 1; k <= NUM_PRE; k++) begin
            c = int'(rr_reg) + k;
            if (c >= NUM_PRE) c = c - NUM_PRE;
            if (!found && pend_reg[c[IW-1:0]]) begin
                found = 1'b1;
                gidx  = c[IW-1:0];
            end
        end
    end

    always_comb begin
        grant_vec = '0;
        if (state_reg == S_IDLE && found) grant_vec[gidx] = 1'b1;
    end

    // A pending entry consumed by a grant on this edge is not lost when re-armed.
    always_comb begin
        ovf_cnt = '0;
        for (int i = 0; i < NUM_PRE; i++) begin
            if (ev[i] && pend_reg[i] && !grant_vec[i]) ovf_cnt = ovf_cnt + 5'd1;
        end
        drop_sum  = {1'b0, drop_reg} + {4'b0, ovf_cnt};
        drop_next = drop_sum[8] ? 8'hFF : drop_sum[7:0];
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_reg <= S_IDLE;
            valid_reg <= 1'b0;
            idx_reg   <= '0;
            dt_reg    <= '0;
            ltp_reg   <= 1'b0;
            rr_reg    <= IW'(NUM_PRE - 1);
            pend_reg  <= '0;
            qt_reg    <= TMAX;
            drop_reg  <= '0;
            for (int i = 0; i < NUM_PRE; i++) begin
                pt_reg[i]   <= TMAX;
                pdt_reg[i]  <= '0;
                pltp_reg[i] <= 1'b0;
            end
        end else begin
            qt_reg <= post_spike ? '0 : sat_inc(qt_reg);
            for (int i = 0; i < NUM_PRE; i++) begin
                pt_reg[i] <= pre_spike[i] ? '0 : sat_inc(pt_reg[i]);
                if (ev[i]) begin
                    pdt_reg[i]  <= ev_dt[i];
                    pltp_reg[i] <= ev_ltp[i];
                end
            end
            pend_reg <= (pend_reg & ~grant_vec) | ev;
            drop_reg <= drop_next;

            case (state_reg)
                S_IDLE: begin
                    if (found) begin
                        valid_reg <= 1'b1;
                        idx_reg   <= gidx;
                        dt_reg    <= pdt_reg[gidx];
                        ltp_reg   <= pltp_reg[gidx];
                        rr_reg    <= gidx;
                        state_reg <= S_OFFER;
                    end
                end
                S_OFFER: begin
                    if (upd.upd_ready) begin
                        valid_reg <= 1'b0;
                        state_reg <= S_IDLE;
                    end
                end
                default: state_reg <= S_IDLE;
            endcase
        end
    end

    // Payload is held after the handshake; reset clears it (upd_ltp included).
    assign upd.upd_valid = valid_reg;
    assign upd.upd_idx   = idx_reg;
    assign upd.upd_dt    = dt_reg;
    assign upd.upd_ltp   = ltp_reg;
    assign busy          = valid_reg | (|pend_reg);
    assign drop_cnt      = drop_reg;
endmodule

// File: tb/tb_stdp_update_sched.sv
// Bench for stdp_update_sched: directed tables, corner sequences, and random traffic
// checked against a timestamp-based reference model.
module tb_stdp_update_sched;
    localparam int NP   = 4;
    localparam int TW   = 4;
    localparam int IW   = 2;
    localparam int TMAX = 15;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic [NP-1:0] pre_spike = '0;
    logic          post_spike = 1'b0;
    logic          busy;
    logic [7:0]    drop_cnt;

    stdp_upd_if #(.TW(TW), .IW(IW)) bus ();

    stdp_update_sched #(.NUM_PRE(NP), .TW(TW), .IW(IW)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .pre_spike  (pre_spike),
        .post_spike (post_spike),
        .upd        (bus),
        .busy       (busy),
        .drop_cnt   (drop_cnt)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    typedef struct {
        int pre, post, rdy;
        int e_valid, e_idx, e_dt, e_ltp, e_busy;
    } vec_t;

    vec_t rr_tab [13];
    vec_t ltp_tab [7];

    // Reference model state: spike timestamps, not timers.
    int last_pre [NP];
    int last_post;
    int now;
    bit m_pend [NP];
    int m_pdt [NP];
    bit m_pltp [NP];
    bit m_valid;
    int m_idx, m_dt, m_rr, m_drop;
    bit m_ltp;

    always @(posedge clk) begin
        if (rst_n && bus.upd_valid && bus.upd_ready)
            $display("XFER t=%0t idx=%0d dt=%0d ltp=%0d drop=%0d", $time, bus.upd_idx, bus.upd_dt, bus.upd_ltp, drop_cnt);
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input int r, input int p, input int q, input int rdy);
        rst_n         = (r != 0);
        pre_spike     = NP'(p);
        post_spike    = (q != 0);
        bus.upd_ready = (rdy != 0);
    endtask

    task automatic chk(input string nm, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endtask

    task automatic chk_out(input string tag, input int v, input int idx, input int dt, input int ltp, input int bsy);
        chk({tag, "_valid"}, int'(bus.upd_valid), v);
        chk({tag, "_busy"}, int'(busy), bsy);
        if (v != 0) begin
            chk({tag, "_idx"}, int'(bus.upd_idx), idx);
            chk({tag, "_dt"}, int'(bus.upd_dt), dt);
            chk({tag, "_ltp"}, int'(bus.upd_ltp), ltp);
        end
    endtask

    task automatic chk_zero(input string tag);
        chk({tag, "_valid"}, int'(bus.upd_valid), 0);
        chk({tag, "_idx"}, int'(bus.upd_idx), 0);
        chk({tag, "_dt"}, int'(bus.upd_dt), 0);
        chk({tag, "_ltp"}, int'(bus.upd_ltp), 0);
        chk({tag, "_busy"}, int'(busy), 0);
        chk({tag, "_drop"}, int'(drop_cnt), 0);
    endtask

    // Leaves the bench at the start of cycle 0 with reset released.
    task automatic do_reset();
        drive(0, 0, 0, 0);
        tick();
        tick();
        drive(1, 0, 0, 0);
    endtask

    function automatic vec_t mk(int pre, int post, int rdy, int v, int idx, int dt, int ltp, int bsy);
        vec_t r;
        r.pre = pre; r.post = post; r.rdy = rdy;
        r.e_valid = v; r.e_idx = idx; r.e_dt = dt; r.e_ltp = ltp; r.e_busy = bsy;
        return r;
    endfunction

    function automatic int since(input int t);
        int d;
        d = now - t - 1;
        return (d > TMAX) ? TMAX : d;
    endfunction

    task automatic model_reset();
        now = 0;
        last_post = -1000;
        for (int i = 0; i < NP; i++) begin
            last_pre[i] = -1000;
            m_pend[i] = 1'b0;
            m_pdt[i] = 0;
            m_pltp[i] = 1'b0;
        end
        m_valid = 1'b0; m_idx = 0; m_dt = 0; m_ltp = 1'b0;
        m_rr = NP - 1; m_drop = 0;
    endtask

    task automatic model_step(input int p, input int q, input int rdy);
        int g;
        g = -1;
        if (!m_valid) begin
            for (int k = 1; k <= NP; k++) begin
                int c;
                c = (m_rr + k) % NP;
                if (g < 0 && m_pend[c]) g = c;
            end
        end
        if (g >= 0) begin
            m_pend[g] = 1'b0;
            m_valid = 1'b1; m_idx = g; m_dt = m_pdt[g]; m_ltp = m_pltp[g]; m_rr = g;
        end else if (m_valid && rdy != 0) begin
            m_valid = 1'b0;
        end
        for (int i = 0; i < NP; i++) begin
            bit evt, l;
            int dt;
            evt = 1'b0; l = 1'b0; dt = 0;
            if (p[i] && q != 0) begin
                evt = 1'b1; dt = 0; l = 1'b1;
            end else if (q != 0 && since(last_pre[i]) < TMAX) begin
                evt = 1'b1; dt = since(last_pre[i]); l = 1'b1;
            end
`ifdef STDP_LTD_EN
            else if (p[i] && since(last_post) < TMAX) begin
                evt = 1'b1; dt = since(last_post); l = 1'b0;
            end
`endif
            if (evt) begin
                if (m_pend[i] && m_drop < 255) m_drop++;
                m_pend[i] = 1'b1; m_pdt[i] = dt; m_pltp[i] = l;
            end
        end
        for (int i = 0; i < NP; i++) if (p[i]) last_pre[i] = now;
        if (q != 0) last_post = now;
        now++;
    endtask

    task automatic random_phase(input int ncyc, input int pre_odds);
        bit any_pend;
        int p, q, rdy;
        model_reset();
        do_reset();
        for (int n = 0; n < ncyc; n++) begin
            any_pend = 1'b0;
            for (int i = 0; i < NP; i++) any_pend |= m_pend[i];
            chk("rnd_valid", int'(bus.upd_valid), int'(m_valid));
            chk("rnd_busy", int'(busy), int'(m_valid | any_pend));
            chk("rnd_drop", int'(drop_cnt), m_drop);
            if (m_valid) begin
                chk("rnd_idx", int'(bus.upd_idx), m_idx);
                chk("rnd_dt", int'(bus.upd_dt), m_dt);
                chk("rnd_ltp", int'(bus.upd_ltp), int'(m_ltp));
            end
            p = 0;
            for (int i = 0; i < NP; i++) if ($urandom_range(0, pre_odds - 1) == 0) p |= (1 << i);
            q = ($urandom_range(0, 5) == 0) ? 1 : 0;
            rdy = ($urandom_range(0, 2) != 0) ? 1 : 0;
            drive(1, p, q, rdy);
            model_step(p, q, rdy);
            tick();
        end
    endtask

    initial begin
        bus.upd_ready = 1'b0;

        // Round-robin with 5 stalled cycles: all four pairs are 1 cycle apart -> dt 0.
        rr_tab[0]  = mk(15, 0, 0, 0, 0, 0, 0, 0);
        rr_tab[1]  = mk(0,  1, 0, 0, 0, 0, 0, 0);
        rr_tab[2]  = mk(0,  0, 0, 0, 0, 0, 0, 1);
        rr_tab[3]  = mk(0,  0, 0, 1, 0, 0, 1, 1);
        rr_tab[4]  = mk(0,  0, 0, 1, 0, 0, 1, 1);
        rr_tab[5]  = mk(0,  0, 1, 1, 0, 0, 1, 1);
        rr_tab[6]  = mk(0,  0, 1, 0, 0, 0, 0, 1);
        rr_tab[7]  = mk(0,  0, 1, 1, 1, 0, 1, 1);
        rr_tab[8]  = mk(0,  0, 1, 0, 0, 0, 0, 1);
        rr_tab[9]  = mk(0,  0, 1, 1, 2, 0, 1, 1);
        rr_tab[10] = mk(0,  0, 1, 0, 0, 0, 0, 1);
        rr_tab[11] = mk(0,  0, 1, 1, 3, 0, 1, 1);
        rr_tab[12] = mk(0,  0, 1, 0, 0, 0, 0, 0);

        // Basic LTP: pre at cycle 0, post at cycle 3 -> timer holds 2.
        ltp_tab[0] = mk(1, 0, 1, 0, 0, 0, 0, 0);
        ltp_tab[1] = mk(0, 0, 1, 0, 0, 0, 0, 0);
        ltp_tab[2] = mk(0, 0, 1, 0, 0, 0, 0, 0);
        ltp_tab[3] = mk(0, 1, 1, 0, 0, 0, 0, 0);
        ltp_tab[4] = mk(0, 0, 1, 0, 0, 0, 0, 1);
        ltp_tab[5] = mk(0, 0, 1, 1, 0, 2, 1, 1);
        ltp_tab[6] = mk(0, 0, 1, 0, 0, 0, 0, 0);

        do_reset();
        chk_zero("reset");
        for (int k = 0; k < 7; k++) begin
            chk_out($sformatf("ltp_c%0d", k), ltp_tab[k].e_valid, ltp_tab[k].e_idx, ltp_tab[k].e_dt, ltp_tab[k].e_ltp, ltp_tab[k].e_busy);
            drive(1, ltp_tab[k].pre, ltp_tab[k].post, ltp_tab[k].rdy);
            tick();
        end

        do_reset();
        for (int k = 0; k < 13; k++) begin
            chk_out($sformatf("rr_c%0d", k), rr_tab[k].e_valid, rr_tab[k].e_idx, rr_tab[k].e_dt, rr_tab[k].e_ltp, rr_tab[k].e_busy);
            drive(1, rr_tab[k].pre, rr_tab[k].post, rr_tab[k].rdy);
            tick();
        end

        // LTD: post at cycle 0, pre on channel 2 at cycle 2 -> qt holds 1.
        do_reset();
        drive(1, 0, 1, 0); tick();
        drive(1, 0, 0, 0); tick();
        drive(1, 4, 0, 0); tick();
        drive(1, 0, 0, 0);
`ifdef STDP_LTD_EN
        chk_out("ltd_c3", 0, 0, 0, 0, 1);
        tick();
        chk_out("ltd_c4", 1, 2, 1, 0, 1);
`else
        chk_out("ltd_c3", 0, 0, 0, 0, 0);
        tick();
        chk_out("ltd_c4", 0, 0, 0, 0, 0);
`endif

        // Largest in-window difference: pre ch3 at cycle 0, post at cycle 15 -> dt 14.
        do_reset();
        drive(1, 8, 0, 0); tick();
        drive(1, 0, 0, 0);
        repeat (14) tick();
        drive(1, 0, 1, 0); tick();
        drive(1, 0, 0, 0); tick();
        tick();
        chk_out("win_max", 1, 3, 14, 1, 1);

        // Saturated timer: post at cycle 16 sees TMAX -> no request.
        do_reset();
        drive(1, 2, 0, 0); tick();
        drive(1, 0, 0, 0);
        repeat (15) tick();
        drive(1, 0, 1, 0); tick();
        drive(1, 0, 0, 0);
        for (int k = 0; k < 4; k++) begin
            chk_out($sformatf("sat_c%0d", 17 + k), 0, 0, 0, 0, 0);
            tick();
        end

        // Tie then two overwrites-in-waiting on channel 0 while stalled.
        do_reset();
        drive(1, 1, 1, 0); tick();
        drive(1, 0, 0, 0); tick();
        chk_out("tie_c2", 1, 0, 0, 1, 1);
        tick();
        drive(1, 0, 1, 0); tick();
        drive(1, 0, 1, 0); tick();
        drive(1, 0, 0, 0);
        chk("drop_c5", int'(drop_cnt), 1);
        chk_out("tie_hold_c5", 1, 0, 0, 1, 1);
        drive(1, 0, 0, 1); tick();
        drive(1, 0, 0, 0);
        chk_out("tie_c6", 0, 0, 0, 0, 1);
        tick();
        chk_out("regrant_c7", 1, 0, 3, 1, 1);

        // Reset while offering, then a lone post spike must not create a request.
        drive(0, 0, 0, 0); tick();
        drive(1, 0, 1, 0);
        chk_zero("rst_mid");
        tick();
        drive(1, 0, 0, 1);
        for (int k = 0; k < 3; k++) begin
            chk_out($sformatf("post_rst_c%0d", k), 0, 0, 0, 0, 0);
            tick();
        end

        random_phase(3000, 8);
        random_phase(1000, 2);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
